// File: rtl/crop_decimate.sv
// Pan/zoom stage: crops a multi-channel pixel stream to a window latched at frame start,
// then keeps every 2^k-th column/line inside it. One cycle of latency from input to output.
module crop_decimate #(
   parameter int CHANNELS          = 3,
   parameter int DATA_WIDTH        = 10,
   parameter int COORD_WIDTH       = 11,
   parameter int MAX_DECIMATE_LOG2 = 3,
   localparam int PW = CHANNELS * DATA_WIDTH,
   localparam int KW = (MAX_DECIMATE_LOG2 > 0) ? $clog2(MAX_DECIMATE_LOG2 + 1) : 1
) (
   input  logic                   clock_in,
   input  logic                   reset_n_in,
   input  logic [PW-1:0]          data_in,
   input  logic                   line_valid_in,
   input  logic                   frame_valid_in,
   input  logic [COORD_WIDTH-1:0] x_crop_start_in,
   input  logic [COORD_WIDTH-1:0] x_crop_end_in,
   input  logic [COORD_WIDTH-1:0] y_crop_start_in,
   input  logic [COORD_WIDTH-1:0] y_crop_end_in,
   input  logic [KW-1:0]          decimate_log2_in,
   output logic [PW-1:0]          data_out,
   output logic                   line_valid_out,
   output logic                   frame_valid_out,
   output logic [COORD_WIDTH-1:0] x_size_out,
   output logic [COORD_WIDTH-1:0] y_size_out,
   output logic                   config_error_out,
   output logic                   frame_done_out
);

   localparam logic [1:0] S_SYNC    = 2'd0;
   localparam logic [1:0] S_IDLE    = 2'd1;
   localparam logic [1:0] S_ACTIVE  = 2'd2;
   localparam logic [1:0] S_BLOCKED = 2'd3;

   localparam logic [KW-1:0] K_MAX = KW'(MAX_DECIMATE_LOG2);

   logic [1:0]             r_state;
   logic                   r_fv, r_lv;
   logic [COORD_WIDTH-1:0] r_x_cnt, r_y_cnt;
   logic [COORD_WIDTH-1:0] r_xs, r_xe, r_ys, r_ye;
   logic [KW-1:0]          r_k;
   logic [PW-1:0]          r_data;
   logic                   r_lv_out, r_fv_out, r_done, r_err;
   logic [COORD_WIDTH-1:0] r_xsz, r_ysz;

   logic                   w_start, w_win_ok, w_act, w_keep, w_fv_out_nxt;
   logic [KW-1:0]          w_k_in, w_k;
   logic [COORD_WIDTH-1:0] w_xs, w_xe, w_ys, w_ye, w_mask, w_dx, w_dy;
   logic [COORD_WIDTH:0]   w_xw, w_yw;
   logic [COORD_WIDTH-1:0] w_xsz, w_ysz;

   // On the latch cycle the live inputs stand in for the shadow registers,
   // so the first frame cycle is filtered with the new window.
   assign w_start  = (r_state == S_IDLE) && !r_fv && frame_valid_in;
   assign w_k_in   = (decimate_log2_in > K_MAX) ? K_MAX : decimate_log2_in;
   assign w_win_ok = (x_crop_end_in > x_crop_start_in) && (y_crop_end_in > y_crop_start_in);

   assign w_xs  = w_start ? x_crop_start_in : r_xs;
   assign w_xe  = w_start ? x_crop_end_in   : r_xe;
   assign w_ys  = w_start ? y_crop_start_in : r_ys;
   assign w_ye  = w_start ? y_crop_end_in   : r_ye;
   assign w_k   = w_start ? w_k_in          : r_k;
   assign w_act = w_start ? w_win_ok        : (r_state == S_ACTIVE);

   assign w_mask = ~({COORD_WIDTH{1'b1}} << w_k);
   assign w_dx   = r_x_cnt - w_xs;
   assign w_dy   = r_y_cnt - w_ys;

   assign w_keep = w_act && line_valid_in && frame_valid_in
                && (r_x_cnt >= w_xs) && (r_x_cnt < w_xe)
                && (r_y_cnt >= w_ys) && (r_y_cnt < w_ye)
                && ((w_dx & w_mask) == '0) && ((w_dy & w_mask) == '0);

   // One extra bit so the ceil rounding cannot overflow on wide windows
   assign w_xw  = {1'b0, w_xe} - {1'b0, w_xs} + {1'b0, w_mask};
   assign w_yw  = {1'b0, w_ye} - {1'b0, w_ys} + {1'b0, w_mask};
   assign w_xsz = COORD_WIDTH'(w_xw >> w_k);
   assign w_ysz = COORD_WIDTH'(w_yw >> w_k);

   assign w_fv_out_nxt = (r_state != S_SYNC) && frame_valid_in;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_state <= S_SYNC;
         r_fv    <= 1'b0;
         r_lv    <= 1'b0;
         r_x_cnt <= '0;
         r_y_cnt <= '0;
      end else begin
         r_fv <= frame_valid_in;
         r_lv <= line_valid_in;

         if (!line_valid_in)   r_x_cnt <= '0;
         else if (~&r_x_cnt)   r_x_cnt <= r_x_cnt + 1'b1;

         if (!frame_valid_in)                                  r_y_cnt <= '0;
         else if (r_lv && !line_valid_in && (~&r_y_cnt))       r_y_cnt <= r_y_cnt + 1'b1;

         case (r_state)
            S_SYNC:    if (!frame_valid_in) r_state <= S_IDLE;
            S_IDLE:    if (w_start) r_state <= w_win_ok ? S_ACTIVE : S_BLOCKED;
            S_ACTIVE,
            S_BLOCKED: if (!frame_valid_in) r_state <= S_IDLE;
            default:   r_state <= S_SYNC;
         endcase
      end
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_xs  <= '0;
         r_xe  <= '0;
         r_ys  <= '0;
         r_ye  <= '0;
         r_k   <= '0;
         r_xsz <= '0;
         r_ysz <= '0;
         r_err <= 1'b0;
      end else if (w_start) begin
         r_xs  <= x_crop_start_in;
         r_xe  <= x_crop_end_in;
         r_ys  <= y_crop_start_in;
         r_ye  <= y_crop_end_in;
         r_k   <= w_k_in;
         r_xsz <= w_win_ok ? w_xsz : '0;
         r_ysz <= w_win_ok ? w_ysz : '0;
         r_err <= !w_win_ok;
      end
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_data   <= '0;
         r_lv_out <= 1'b0;
         r_fv_out <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_lv_out <= w_keep;
         if (w_keep) r_data <= data_in;
         r_fv_out <= w_fv_out_nxt;
         r_done   <= r_fv_out && !w_fv_out_nxt;
      end
   end

   assign data_out         = r_data;
   assign line_valid_out   = r_lv_out;
   assign frame_valid_out  = r_fv_out;
   assign frame_done_out   = r_done;
   assign x_size_out       = r_xsz;
   assign y_size_out       = r_ysz;
   assign config_error_out = r_err;

endmodule

// File: tb/tb_crop_decimate.sv
// Randomized and directed frames checked cycle by cycle against a coordinate-level model
// of the crop/decimate rules.
module tb_crop_decimate;
   localparam int CH = 3, DW = 10, CW = 11, KM = 3;
   localparam int PW = CH * DW, KW = 2;
   localparam int W = 16, H = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [PW-1:0] data_in = '0;
   logic          lv_in = 1'b0, fv_in = 1'b0;
   logic [CW-1:0] xs_in = '0, xe_in = '0, ys_in = '0, ye_in = '0;
   logic [KW-1:0] k_in = '0;
   logic [PW-1:0] data_out;
   logic          line_valid_out, frame_valid_out, config_error_out, frame_done_out;
   logic [CW-1:0] x_size_out, y_size_out;

   always #5 clk = ~clk;

   crop_decimate #(.CHANNELS(CH), .DATA_WIDTH(DW), .COORD_WIDTH(CW), .MAX_DECIMATE_LOG2(KM)) dut (
      .clock_in(clk), .reset_n_in(rst_n), .data_in(data_in),
      .line_valid_in(lv_in), .frame_valid_in(fv_in),
      .x_crop_start_in(xs_in), .x_crop_end_in(xe_in),
      .y_crop_start_in(ys_in), .y_crop_end_in(ye_in),
      .decimate_log2_in(k_in),
      .data_out(data_out), .line_valid_out(line_valid_out), .frame_valid_out(frame_valid_out),
      .x_size_out(x_size_out), .y_size_out(y_size_out),
      .config_error_out(config_error_out), .frame_done_out(frame_done_out)
   );

   int n_chk = 0, n_pass = 0;

   // model state
   bit            synced = 1'b0, fr_ok = 1'b0;
   logic          exp_lv = 1'b0, exp_fv = 1'b0, exp_done = 1'b0;
   logic [PW-1:0] exp_data = '0;
   int            exp_xsz = 0, exp_ysz = 0, exp_err = 0;
   int            nexp = 0, nstrobe = 0, ndone = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Check the outputs produced by the previous edge, then drive the next input cycle.
   task automatic tick(input logic fv, input logic lv, input logic [PW-1:0] d, input bit keep);
      logic prev;
      @(negedge clk);
      chk("line_valid_out", line_valid_out, exp_lv);
      chk("data_out", data_out, exp_data);
      chk("frame_valid_out", frame_valid_out, exp_fv);
      chk("frame_done_out", frame_done_out, exp_done);
      if (line_valid_out === 1'b1) nstrobe++;
      if (frame_done_out === 1'b1) ndone++;
      fv_in = fv; lv_in = lv; data_in = d;
      prev     = exp_fv;
      exp_fv   = synced && fv;
      exp_done = prev && !exp_fv;
      if (!fv) synced = 1'b1;
      exp_lv = keep;
      if (keep) exp_data = d;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_lv"}, line_valid_out, 0);
      chk({tag, "_data"}, data_out, 0);
      chk({tag, "_fv"}, frame_valid_out, 0);
      chk({tag, "_done"}, frame_done_out, 0);
      chk({tag, "_xsz"}, x_size_out, 0);
      chk({tag, "_ysz"}, y_size_out, 0);
      chk({tag, "_err"}, config_error_out, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      synced = 1'b0; fr_ok = 1'b0;
      exp_lv = 1'b0; exp_fv = 1'b0; exp_done = 1'b0; exp_data = '0;
      exp_xsz = 0; exp_ysz = 0; exp_err = 0;
      @(negedge clk);
      chk("rst_hold_fv", frame_valid_out, 0);
      rst_n = 1'b1;
   endtask

   // One W x H frame; the model sees only the window sampled at frame start.
   task automatic frame(input int xs, input int xe, input int ys, input int ye, input int k,
                        input int xs_mid, input int rst_line);
      int  kk, st;
      bit  valid, keep;
      xs_in = CW'(xs); xe_in = CW'(xe); ys_in = CW'(ys); ye_in = CW'(ye); k_in = KW'(k);
      kk    = (k > KM) ? KM : k;
      st    = 1 << kk;
      valid = (xe > xs) && (ye > ys);
      fr_ok = synced;
      nexp = 0; nstrobe = 0; ndone = 0;
      if (fr_ok) begin
         exp_err = valid ? 0 : 1;
         exp_xsz = valid ? (xe - xs + st - 1) / st : 0;
         exp_ysz = valid ? (ye - ys + st - 1) / st : 0;
      end
      for (int y = 0; y < H; y++) begin
         if (y == 1) xs_in = CW'(xs_mid);
         for (int x = 0; x < W; x++) begin
            if (y == rst_line && x == 5) do_reset();
            keep = fr_ok && valid && x >= xs && x < xe && y >= ys && y < ye
                && ((x - xs) % st) == 0 && ((y - ys) % st) == 0;
            if (keep) nexp++;
            tick(1'b1, 1'b1, PW'($urandom), keep);
         end
         repeat (3) tick(1'b1, 1'b0, PW'($urandom), 1'b0);
      end
      repeat (2) tick(1'b1, 1'b0, PW'($urandom), 1'b0);
      repeat (4) tick(1'b0, 1'b0, PW'($urandom), 1'b0);
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_strobes"}, nstrobe, nexp);
      chk({tag, "_done_cnt"}, ndone, fr_ok ? 1 : 0);
      chk({tag, "_xsize"}, x_size_out, exp_xsz);
      chk({tag, "_ysize"}, y_size_out, exp_ysz);
      chk({tag, "_err"}, config_error_out, exp_err);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (3) tick(1'b0, 1'b0, '0, 1'b0);

      frame(2, 10, 3, 7, 0, 2, -1);
      end_checks("t1");
      chk("t1_32", nstrobe, 32);
      chk("t1_x8", x_size_out, 8);
      chk("t1_y4", y_size_out, 4);

      frame(2, 9, 3, 7, 1, 2, -1);
      end_checks("t2");
      chk("t2_8", nstrobe, 8);
      chk("t2_x4", x_size_out, 4);
      chk("t2_y2", y_size_out, 2);

      frame(2, 10, 3, 7, 0, 4, -1);
      end_checks("t3a");
      chk("t3a_32", nstrobe, 32);
      frame(4, 10, 3, 7, 0, 4, -1);
      end_checks("t3b");
      chk("t3b_24", nstrobe, 24);

      frame(5, 5, 3, 7, 0, 5, -1);
      end_checks("t4a");
      chk("t4a_err", config_error_out, 1);
      frame(2, 10, 3, 7, 0, 2, -1);
      end_checks("t4b");
      chk("t4b_err", config_error_out, 0);

      frame(2, 10, 3, 7, 2, 2, 4);
      end_checks("t5a");
      frame(2, 10, 3, 7, 0, 2, -1);
      end_checks("t5b");

      frame(0, 2047, 0, 12, 0, 0, -1);
      end_checks("t6a");
      chk("t6a_192", nstrobe, 192);
      frame(1, 2047, 2, 12, 3, 1, -1);
      end_checks("t6b");
      chk("t6b_x256", x_size_out, 256);

      for (int i = 0; i < 12; i++) begin
         int xs, xe, ys, ye;
         xs = $urandom_range(0, 15);
         xe = ($urandom_range(0, 4) == 0) ? 2047 : $urandom_range(0, 18);
         ys = $urandom_range(0, 11);
         ye = $urandom_range(0, 13);
         frame(xs, xe, ys, ye, $urandom_range(0, 3), $urandom_range(0, 15), -1);
         end_checks("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
